// File: rtl/layers_frame_arbiter.sv
// layers_frame_arbiter: frame-aware round-robin merge of layer byte streams with stall abort; LAYERS_ARB_HEADER_EN adds a per-frame header byte
module layers_frame_arbiter #(
  parameter int LAYER_COUNT = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk_core,
  input  logic                     clk_core_rst,
  input  logic [LAYER_COUNT*8-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]   s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]   s_axis_tlast,
  output logic [LAYER_COUNT-1:0]   s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic [7:0]               m_axis_tdest,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [LAYER_COUNT-1:0]   cfg_layer_enable,
  input  logic [CNT_W-1:0]         cfg_stall_timeout,
  output logic                     status_busy,
  output logic [3:0]               status_grant_layer,
  output logic [LAYER_COUNT-1:0]   stat_frame_done,
  output logic [LAYER_COUNT-1:0]   stat_timeout
);
`ifdef LAYERS_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE, DATA, ABORT, HDR} state_t;
  localparam state_t GRANT_ST = HDR;
`else
  typedef enum logic [1:0] {IDLE, DATA, ABORT} state_t;
  localparam state_t GRANT_ST = DATA;
`endif
  state_t state, state_nx;
  logic [3:0] gnt, last_grant, pick, pick_hi, pick_lo;
  logic [LAYER_COUNT-1:0] req, gnt_oh, busy_oh, drop_pending, drop_clr;
  logic [CNT_W-1:0] cnt;
  logic [15:0] vld_pad, last_pad;
  logic [7:0] data_arr [16];
  logic found_hi, sel_vld, sel_last, acc, stall_hit;
  assign req = s_axis_tvalid & cfg_layer_enable & ~drop_pending;
  assign vld_pad = 16'(s_axis_tvalid);
  assign last_pad = 16'(s_axis_tlast);
  assign sel_vld = vld_pad[gnt];
  assign sel_last = last_pad[gnt];
  assign acc = state == DATA && sel_vld && m_axis_tready;
  assign stall_hit = state == DATA && !acc && cfg_stall_timeout != '0 && cnt == cfg_stall_timeout;
  assign busy_oh = state == IDLE ? '0 : gnt_oh;
  assign drop_clr = drop_pending & ~busy_oh & s_axis_tvalid & s_axis_tlast;
  assign status_busy = state != IDLE;
  assign status_grant_layer = gnt;
  always_comb begin
    for (int j = 0; j < 16; j++) data_arr[j] = 8'h00;
    for (int j = 0; j < LAYER_COUNT; j++) data_arr[j] = s_axis_tdata[j*8 +: 8];
    for (int j = 0; j < LAYER_COUNT; j++) gnt_oh[j] = gnt == 4'(j);
  end
  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    found_hi = 1'b0;
    for (int j = LAYER_COUNT-1; j >= 0; j--) begin
      if (req[j]) begin
        pick_lo = 4'(j);
        if (j > int'(last_grant)) begin
          pick_hi = 4'(j);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end
  always_comb begin
    s_axis_tready = (drop_pending & ~busy_oh) | ((state == DATA && m_axis_tready) ? gnt_oh : '0);
    m_axis_tvalid = state == DATA ? sel_vld : state != IDLE;
    m_axis_tlast = state == DATA ? sel_last : state == ABORT;
    m_axis_tdest = state == IDLE ? 8'h00 : {4'h0, gnt} + 8'd1;
`ifdef LAYERS_ARB_HEADER_EN
    m_axis_tdata = state == DATA ? data_arr[gnt] : state == HDR ? {4'hA, gnt + 4'd1} : 8'h00;
`else
    m_axis_tdata = state == DATA ? data_arr[gnt] : 8'h00;
`endif
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |req ? GRANT_ST : IDLE;
`ifdef LAYERS_ARB_HEADER_EN
      HDR: state_nx = m_axis_tready ? DATA : HDR;
`endif
      DATA: state_nx = (acc && sel_last) ? IDLE : stall_hit ? ABORT : DATA;
      ABORT: state_nx = m_axis_tready ? IDLE : ABORT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_core) begin
    if (clk_core_rst) begin
      state <= IDLE;
      gnt <= '0;
      last_grant <= 4'(LAYER_COUNT-1);
      drop_pending <= '0;
      cnt <= '0;
      stat_frame_done <= '0;
      stat_timeout <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) begin
        gnt <= pick;
        last_grant <= pick;
      end
      cnt <= (state != DATA || acc) ? '0 : !sel_vld ? cnt + 1'b1 : cnt;
      drop_pending <= (drop_pending & ~drop_clr) | ((state == ABORT && m_axis_tready) ? gnt_oh : '0);
      stat_frame_done <= (acc && sel_last) ? gnt_oh : '0;
      stat_timeout <= (state == ABORT && m_axis_tready) ? gnt_oh : '0;
    end
  end
endmodule

// File: tb/tb_layers_frame_arbiter.sv
// tb_layers_frame_arbiter: scoreboard bench for layers_frame_arbiter (header byte expected when LAYERS_ARB_HEADER_EN is defined)
module tb_layers_frame_arbiter;
  localparam int LC = 5;
  localparam int CW = 16;
  logic clk_core = 1'b0;
  logic clk_core_rst = 1'b1;
  logic [LC*8-1:0] s_axis_tdata = '0;
  logic [LC-1:0] s_axis_tvalid = '0, s_axis_tlast = '0, s_axis_tready;
  logic [7:0] m_axis_tdata, m_axis_tdest;
  logic m_axis_tlast, m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [LC-1:0] cfg_layer_enable = '1;
  logic [CW-1:0] cfg_stall_timeout = '0;
  logic status_busy;
  logic [3:0] status_grant_layer;
  logic [LC-1:0] stat_frame_done, stat_timeout;
  int asserts = 0, fails = 0;
  logic [16:0] exp_q [$];
  logic [16:0] exp_e;
  logic [9:0] src_q [LC][$];
  logic [9:0] src_e;
  logic [LC-1:0] hs, drove_bubble = '0;
  int done_cnt [LC];
  int to_cnt [LC];
  layers_frame_arbiter #(.LAYER_COUNT(LC), .CNT_W(CW)) dut (
    .clk_core(clk_core), .clk_core_rst(clk_core_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .cfg_layer_enable(cfg_layer_enable), .cfg_stall_timeout(cfg_stall_timeout),
    .status_busy(status_busy), .status_grant_layer(status_grant_layer),
    .stat_frame_done(stat_frame_done), .stat_timeout(stat_timeout)
  );
  always #5 clk_core = ~clk_core;
  // Per-layer source model: entries with bit 9 clear are one-cycle bubbles.
  initial forever begin
    @(negedge clk_core);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk_core);
    #1;
    for (int i = 0; i < LC; i++) begin
      if ((hs[i] || drove_bubble[i]) && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        src_e = src_q[i][0];
        s_axis_tvalid[i] = src_e[9];
        s_axis_tlast[i] = src_e[8];
        s_axis_tdata[i*8 +: 8] = src_e[7:0];
        drove_bubble[i] = !src_e[9];
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tlast[i] = 1'b0;
        drove_bubble[i] = 1'b0;
      end
    end
  end
  initial forever begin
    @(negedge clk_core);
    if (!clk_core_rst)
      for (int i = 0; i < LC; i++) begin
        if (stat_frame_done[i]) done_cnt[i]++;
        if (stat_timeout[i]) to_cnt[i]++;
      end
    if (m_axis_tvalid && m_axis_tready) begin
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got data=%h dest=%0d last=%b, required no beat", m_axis_tdata, m_axis_tdest, m_axis_tlast);
      end else begin
        exp_e = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdest, m_axis_tdata} !== exp_e) begin
          fails++;
          $display("FAIL beat: got last=%b dest=%0d data=%h, required last=%b dest=%0d data=%h",
                   m_axis_tlast, m_axis_tdest, m_axis_tdata, exp_e[16], exp_e[15:8], exp_e[7:0]);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000");
    $fatal(1, "timeout");
  end
  task automatic push_src(input int l, input logic [7:0] d, input logic last);
    src_q[l].push_back({1'b1, last, d});
  endtask
  task automatic push_bubbles(input int l, input int n);
    for (int k = 0; k < n; k++) src_q[l].push_back(10'h000);
  endtask
  task automatic push_exp(input int l, input logic [7:0] d, input logic last);
    exp_q.push_back({last, 8'(l+1), d});
  endtask
  task automatic push_hdr(input int l);
`ifdef LAYERS_ARB_HEADER_EN
    exp_q.push_back({1'b0, 8'(l+1), 4'hA, 4'(l+1)});
`else
    if (l < 0) exp_q.delete();
`endif
  endtask
  task automatic frame(input int l, input int base, input int n, input bit src_en, input bit exp_en);
    if (exp_en) push_hdr(l);
    for (int k = 0; k < n; k++) begin
      if (src_en) push_src(l, 8'(base+k), k == n-1);
      if (exp_en) push_exp(l, 8'(base+k), k == n-1);
    end
  endtask
  task automatic do_reset();
    clk_core_rst = 1'b1;
    m_axis_tready = 1'b1;
    cfg_layer_enable = '1;
    cfg_stall_timeout = '0;
    for (int i = 0; i < LC; i++) src_q[i].delete();
    exp_q.delete();
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    clk_core_rst = 1'b0;
    for (int i = 0; i < LC; i++) begin
      done_cnt[i] = 0;
      to_cnt[i] = 0;
    end
  endtask
  task automatic wait_done(input string name, input int budget, input bit toggle);
    int n = 0;
    bit pend;
    do begin
      @(posedge clk_core);
      #1;
      n++;
      if (toggle) m_axis_tready = ((n / 4) % 2) == 0;
      pend = exp_q.size() != 0 || status_busy;
      for (int i = 0; i < LC; i++) if (src_q[i].size() != 0) pend = 1'b1;
    end while (pend && n < budget);
    m_axis_tready = 1'b1;
    asserts++;
    if (pend) begin
      fails++;
      $display("FAIL %s_drain: got %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), n);
    end
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk_core);
    #1;
    asserts++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest} !== 18'h0) begin
      fails++;
      $display("FAIL reset_master: got %b, required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest});
    end
    asserts++;
    if (s_axis_tready !== '0) begin
      fails++;
      $display("FAIL reset_tready: got %b, required 0", s_axis_tready);
    end
    asserts++;
    if ({status_busy, status_grant_layer} !== 5'h0) begin
      fails++;
      $display("FAIL reset_status: got busy=%b grant=%0d, required 0", status_busy, status_grant_layer);
    end
    asserts++;
    if ({stat_frame_done, stat_timeout} !== '0) begin
      fails++;
      $display("FAIL reset_stats: got %b, required 0", {stat_frame_done, stat_timeout});
    end
    do_reset();
  endtask
  task automatic test_two_layers();
    do_reset();
    frame(0, 8'h01, 3, 1, 1);
    frame(2, 8'h21, 3, 1, 1);
    wait_done("two_layers", 100, 0);
    asserts++;
    if (done_cnt[0] !== 1 || done_cnt[2] !== 1) begin
      fails++;
      $display("FAIL two_layers_done: got l0=%0d l2=%0d, required 1 and 1", done_cnt[0], done_cnt[2]);
    end
    asserts++;
    if (status_grant_layer !== 4'd2) begin
      fails++;
      $display("FAIL two_layers_grant: got %0d, required 2", status_grant_layer);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < LC; l++) frame(l, 16 * l + 4 * f, 2, 1, 1);
    wait_done("round_robin", 300, 0);
    for (int l = 0; l < LC; l++) begin
      asserts++;
      if (done_cnt[l] !== 2) begin
        fails++;
        $display("FAIL round_robin_done%0d: got %0d, required 2", l, done_cnt[l]);
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    cfg_stall_timeout = 16'd3;
    frame(4, 8'hC0, 10, 1, 1);
    wait_done("backpressure", 300, 1);
    asserts++;
    if (to_cnt[4] !== 0 || done_cnt[4] !== 1) begin
      fails++;
      $display("FAIL backpressure_stats: got timeout=%0d done=%0d, required 0 and 1", to_cnt[4], done_cnt[4]);
    end
  endtask
  task automatic test_short_stall();
    do_reset();
    cfg_stall_timeout = 16'd8;
    push_hdr(2);
    push_src(2, 8'h41, 0);
    push_exp(2, 8'h41, 0);
    push_bubbles(2, 6);
    push_src(2, 8'h42, 1);
    push_exp(2, 8'h42, 1);
    wait_done("short_stall", 100, 0);
    asserts++;
    if (to_cnt[2] !== 0 || done_cnt[2] !== 1) begin
      fails++;
      $display("FAIL short_stall_stats: got timeout=%0d done=%0d, required 0 and 1", to_cnt[2], done_cnt[2]);
    end
  endtask
  task automatic test_stall();
    do_reset();
    cfg_stall_timeout = 16'd8;
    push_hdr(1);
    push_src(1, 8'h11, 0);
    push_exp(1, 8'h11, 0);
    push_src(1, 8'h12, 0);
    push_exp(1, 8'h12, 0);
    push_exp(1, 8'h00, 1);
    push_bubbles(1, 20);
    push_src(1, 8'h13, 0);
    push_src(1, 8'h14, 1);
    frame(3, 8'h31, 2, 1, 1);
    wait_done("stall", 200, 0);
    asserts++;
    if (to_cnt[1] !== 1 || done_cnt[1] !== 0) begin
      fails++;
      $display("FAIL stall_l1_stats: got timeout=%0d done=%0d, required 1 and 0", to_cnt[1], done_cnt[1]);
    end
    asserts++;
    if (done_cnt[3] !== 1) begin
      fails++;
      $display("FAIL stall_l3_done: got %0d, required 1", done_cnt[3]);
    end
    asserts++;
    if (s_axis_tready !== '0) begin
      fails++;
      $display("FAIL stall_drain_end: got tready=%b, required 0", s_axis_tready);
    end
  endtask
  task automatic test_enable();
    do_reset();
    cfg_layer_enable = 5'b11101;
    frame(1, 8'h51, 2, 1, 0);
    repeat (10) @(posedge clk_core);
    #1;
    asserts++;
    if (s_axis_tready[1] !== 1'b0 || status_busy !== 1'b0) begin
      fails++;
      $display("FAIL enable_off: got tready1=%b busy=%b, required 0 and 0", s_axis_tready[1], status_busy);
    end
    @(negedge clk_core);
    frame(1, 8'h51, 2, 0, 1);
    cfg_layer_enable = '1;
    wait_done("enable", 100, 0);
    asserts++;
    if (done_cnt[1] !== 1) begin
      fails++;
      $display("FAIL enable_on_done: got %0d, required 1", done_cnt[1]);
    end
  endtask
  task automatic test_reset_midframe();
    int n = 0;
    do_reset();
    frame(0, 8'h61, 6, 1, 0);
    push_hdr(0);
    push_exp(0, 8'h61, 0);
    push_exp(0, 8'h62, 0);
    do begin
      @(posedge clk_core);
      #1;
      n++;
    end while (exp_q.size() != 0 && n < 50);
    clk_core_rst = 1'b1;
    m_axis_tready = 1'b0;
    src_q[0].delete();
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL midframe_start: got %0d beats pending, required 0", exp_q.size());
    end
    @(posedge clk_core);
    #1;
    asserts++;
    if (m_axis_tvalid !== 1'b0 || status_busy !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset: got valid=%b busy=%b, required 0 and 0", m_axis_tvalid, status_busy);
    end
    @(negedge clk_core);
    clk_core_rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) @(posedge clk_core);
    #1;
    asserts++;
    if (m_axis_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL midframe_after: got valid=%b, required 0", m_axis_tvalid);
    end
  endtask
  task automatic test_header();
    do_reset();
    push_hdr(3);
    push_src(3, 8'h11, 0);
    push_exp(3, 8'h11, 0);
    push_src(3, 8'h22, 1);
    push_exp(3, 8'h22, 1);
    wait_done("header", 100, 0);
    asserts++;
    if (done_cnt[3] !== 1) begin
      fails++;
      $display("FAIL header_done: got %0d, required 1", done_cnt[3]);
    end
  endtask
  initial begin
    test_reset();
    test_two_layers();
    test_round_robin();
    test_backpressure();
    test_short_stall();
    test_stall();
    test_enable();
    test_reset_midframe();
    test_header();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/layers_frame_arbiter.md
Name: layers_frame_arbiter

Overview:
- Frame-aware round-robin arbiter that merges the per-layer byte-wide MISO frame streams into one AXI-Stream toward the frames buffer FIFO.
- A grant is held for a whole frame, from first beat to tlast, so frames never interleave.
- A stall watchdog aborts frames from layers that stop mid-frame and drains their remainder, so one dead layer cannot block readout.
- Runs on clk_core.

Parameters:
- LAYER_COUNT, 5, number of layer input streams (1..15).
- CNT_W, 16, width of the stall timeout counter and config.

Ports:
- clk_core  input  1  core clock.
- clk_core_rst  input  1  reset; one clock, synchronous, active-high.
- s_axis_tdata  input  LAYER_COUNT*8  per-layer frame bytes; layer i on bits [i*8+7:i*8].
- s_axis_tvalid  input  LAYER_COUNT  per-layer valid.
- s_axis_tlast  input  LAYER_COUNT  per-layer end of frame.
- s_axis_tready  output  LAYER_COUNT  per-layer ready.
- m_axis_tdata  output  8  merged byte.
- m_axis_tdest  output  8  source layer ID (index+1).
- m_axis_tlast  output  1  end of merged frame.
- m_axis_tvalid  output  1  merged valid.
- m_axis_tready  input  1  downstream ready.
- cfg_layer_enable  input  LAYER_COUNT  1 = layer takes part in arbitration.
- cfg_stall_timeout  input  CNT_W  abort threshold in cycles; 0 disables the watchdog.
- status_busy  output  1  high while a frame is granted.
- status_grant_layer  output  4  index of the current or last granted layer.
- stat_frame_done  output  LAYER_COUNT  one-cycle pulse per completed frame, per layer.
- stat_timeout  output  LAYER_COUNT  one-cycle pulse per aborted frame, per layer.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, drop_pending = 0, timeout counter 0.
  - last_grant = LAYER_COUNT-1, so layer 0 has top priority after reset.
- Request rule: req[i] = s_axis_tvalid[i] & cfg_layer_enable[i] & ~drop_pending[i].
- IDLE:
  - With any req set, pick the first requester scanning from last_grant+1 with wrap mod LAYER_COUNT.
  - Register the winner in gnt and last_grant; go to DATA (or HDR with the optional feature).
  - Arbitration latency is one cycle: no beat is accepted in the IDLE cycle.
- DATA:
  - Pass-through path: m_axis_tdata/tlast/tvalid are taken from layer gnt; m_axis_tdest = gnt+1.
  - s_axis_tready[gnt] = m_axis_tready; every other layer's tready is 0 unless drained.
  - When a beat is accepted with tlast: pulse stat_frame_done[gnt] and return to IDLE. Back-to-back frames therefore have a one-cycle gap.
- Watchdog:
  - In DATA, the counter increments each cycle that s_axis_tvalid[gnt] = 0.
  - It clears on any accepted beat.
  - Cycles where the source is valid but m_axis_tready is low do not count.
  - When counter == cfg_stall_timeout and the threshold is non-zero, go to ABORT.
- ABORT:
  - Drive m_axis_tvalid = 1, tdata = 8'h00, tlast = 1, tdest = gnt+1.
  - Hold until m_axis_tready.
  - On acceptance: set drop_pending[gnt], pulse stat_timeout[gnt], go to IDLE.
- Drain:
  - While drop_pending[i] = 1 and layer i is not granted, s_axis_tready[i] = 1 and its beats are discarded.
  - drop_pending[i] clears on an accepted beat with tlast.
- cfg_layer_enable falling mid-frame: the current frame completes normally; the layer is excluded from the next arbitration.
- cfg_stall_timeout changing mid-frame: the new value is compared immediately.
- Single requester: it is re-granted each frame, with the one-cycle IDLE gap.
- Reset asserted mid-frame: state returns to IDLE at once, the partial frame is dropped and downstream sees no tlast. Downstream is reset in the same domain.

Optional Feature:
- Macro LAYERS_ARB_HEADER_EN.
- Defined:
  - After a grant, state HDR emits one byte {4'hA, gnt+1} with tlast = 0 before any payload.
  - The source tready is held 0 during HDR; HDR waits on m_axis_tready, then goes to DATA.
  - The watchdog does not run in HDR.
- Undefined: HDR does not exist and IDLE goes directly to DATA.

Test Plan:
- Reset, then layers 0 and 2 each present a 3-byte frame at the same time -> layer 0 frame out with tdest=1, then layer 2 with tdest=3; stat_frame_done[0] and [2] pulse once each.
- All 5 layers streaming continuously -> grant order 0,1,2,3,4,0; no interleave inside any frame.
- m_axis_tready toggled 50% during a 10-byte frame -> all 10 bytes intact and in order; stat_timeout stays 0.
- cfg_stall_timeout=8, layer 1 stalls after 2 bytes for 20 cycles ->
  - byte 0x00 with tlast and tdest=2, then stat_timeout[1] pulses;
  - layer 1's later bytes up to its tlast are drained with none on the master;
  - layer 3 is served next.
- cfg_layer_enable=5'b11101 with layer 1 valid -> s_axis_tready[1]=0 and no layer 1 output; enable it -> its frame is granted.
- With LAYERS_ARB_HEADER_EN, a layer 3 frame {11,22} -> master sees A4,11,22 with tlast on 22.
